// File: rtl/usr_access_capture.sv
// Captures a multi-word user-access frame from the configuration data path,
// verifies its trailing XOR checksum and presents only complete, validated payloads.
module usr_access_capture #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_WORDS      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [DATA_WIDTH-1:0]               CFG_DATA,
    input  logic                                CFG_VALID,
    input  logic                                REARM,
    output logic [(NUM_WORDS-1)*DATA_WIDTH-1:0] DATA,
    output logic                                DATAVALID,
    output logic                                BUSY,
    output logic                                ERR,
    output logic [1:0]                          ERR_CODE
);

    localparam int CW = $clog2(NUM_WORDS);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = (NUM_WORDS - 1) * DATA_WIDTH;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE,
        ERROR
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] shadow [NUM_WORDS-1];
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] acc;
    logic [IW-1:0]         idle_cnt;

    logic [PW-1:0] data_q;
    logic          dvalid_q;
    logic          busy_q;
    logic          err_q;
    logic [1:0]    err_code_q;

    logic take_first, take_word, chk_ok, chk_bad, tmo, clr, idle_inc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // REARM outranks everything, so a word arriving with it is simply dropped.
    always_comb begin
        state_nxt  = state;
        take_first = 1'b0;
        take_word  = 1'b0;
        chk_ok     = 1'b0;
        chk_bad    = 1'b0;
        tmo        = 1'b0;
        clr        = 1'b0;
        idle_inc   = 1'b0;
        if (REARM) begin
            clr       = 1'b1;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (CFG_VALID) begin
                        take_first = 1'b1;
                        state_nxt  = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (CFG_VALID) begin
                        if (cnt == LAST_IDX) begin
                            if (CFG_DATA == acc) begin
                                chk_ok    = 1'b1;
                                state_nxt = DONE;
                            end else begin
                                chk_bad   = 1'b1;
                                state_nxt = ERROR;
                            end
                        end else begin
                            take_word = 1'b1;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        tmo       = 1'b1;
                        state_nxt = ERROR;
                    end else begin
                        idle_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_WORDS - 1; i++) begin
                shadow[i] <= '0;
            end
            cnt        <= '0;
            acc        <= '0;
            idle_cnt   <= '0;
            data_q     <= '0;
            dvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            busy_q <= (state_nxt == CAPTURE);
            if (clr) begin
                cnt        <= '0;
                acc        <= '0;
                idle_cnt   <= '0;
                data_q     <= '0;
                dvalid_q   <= 1'b0;
                err_q      <= 1'b0;
                err_code_q <= 2'b00;
            end
            if (take_first) begin
                shadow[0] <= CFG_DATA;
                acc       <= CFG_DATA;
                cnt       <= CW'(1);
                idle_cnt  <= '0;
            end
            if (take_word) begin
                for (int i = 0; i < NUM_WORDS - 1; i++) begin
                    if (int'(cnt) == i) begin
                        shadow[i] <= CFG_DATA;
                    end
                end
                acc      <= acc ^ CFG_DATA;
                cnt      <= cnt + CW'(1);
                idle_cnt <= '0;
            end
            if (idle_inc) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
            // The payload register is only ever loaded from a fully verified bank.
            if (chk_ok) begin
                for (int i = 0; i < NUM_WORDS - 1; i++) begin
                    data_q[i*DATA_WIDTH +: DATA_WIDTH] <= shadow[i];
                end
                dvalid_q <= 1'b1;
            end
            if (chk_bad) begin
                err_q      <= 1'b1;
                err_code_q <= 2'b01;
            end
            if (tmo) begin
                err_q      <= 1'b1;
                err_code_q <= 2'b10;
            end
        end
    end

    assign DATA      = data_q;
    assign DATAVALID = dvalid_q;
    assign BUSY      = busy_q;
    assign ERR       = err_q;
    assign ERR_CODE  = err_code_q;

endmodule

// File: tb/tb_usr_access_capture.sv
// Scoreboard bench for usr_access_capture: stimulus queues expected frame
// results, a monitor pops and compares them whenever a result appears.
module tb_usr_access_capture;

    localparam int DW = 32;
    localparam int NW = 3;
    localparam int TO = 8;
    localparam int PW = (NW - 1) * DW;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] CFG_DATA;
    logic          CFG_VALID;
    logic          REARM;
    logic [PW-1:0] DATA;
    logic          DATAVALID;
    logic          BUSY;
    logic          ERR;
    logic [1:0]    ERR_CODE;

    typedef struct packed {
        logic          dv;
        logic          err;
        logic [1:0]    code;
        logic [PW-1:0] data;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_prev;
    logic mon_evt;
    exp_t mon_e;

    usr_access_capture #(
        .DATA_WIDTH    (DW),
        .NUM_WORDS     (NW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CFG_DATA (CFG_DATA),
        .CFG_VALID(CFG_VALID),
        .REARM    (REARM),
        .DATA     (DATA),
        .DATAVALID(DATAVALID),
        .BUSY     (BUSY),
        .ERR      (ERR),
        .ERR_CODE (ERR_CODE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        CFG_VALID = 1'b1;
        CFG_DATA  = d;
        tick();
        CFG_VALID = 1'b0;
        CFG_DATA  = '0;
    endtask

    task automatic rearm();
        REARM = 1'b1;
        tick();
        REARM = 1'b0;
    endtask

    task automatic push(input logic dv, input logic err, input logic [1:0] code,
                        input logic [PW-1:0] data);
        exp_t e;
        e.dv   = dv;
        e.err  = err;
        e.code = code;
        e.data = data;
        expq.push_back(e);
    endtask

    // Monitor: a new result is the rising edge of DATAVALID|ERR.
    initial begin
        mon_prev = 1'b0;
        forever begin
            @(negedge CLK);
            mon_evt = DATAVALID | ERR;
            if (mon_evt && !mon_prev) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result dv=%0b err=%0b code=%0b required=none",
                             DATAVALID, ERR, ERR_CODE);
                end else begin
                    mon_e = expq.pop_front();
                    chk("res_datavalid", PW'(DATAVALID), PW'(mon_e.dv));
                    chk("res_err", PW'(ERR), PW'(mon_e.err));
                    chk("res_err_code", PW'(ERR_CODE), PW'(mon_e.code));
                    chk("res_data", DATA, mon_e.data);
                end
            end
            mon_prev = mon_evt;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        RST       = 1'b1;
        CFG_VALID = 1'b0;
        CFG_DATA  = '0;
        REARM     = 1'b0;

        for (int i = 0; i < 6; i++) begin
            CFG_VALID = (i % 2 == 0);
            CFG_DATA  = 32'hFFFF0000 + DW'(i);
            tick();
            chk("rst_data", DATA, '0);
            chk("rst_flags", PW'({DATAVALID, BUSY, ERR, ERR_CODE}), '0);
        end
        CFG_VALID = 1'b0;
        RST       = 1'b0;
        tick();
        tick();
        chk("post_rst_flags", PW'({DATAVALID, BUSY, ERR, ERR_CODE}), '0);

        push(1'b1, 1'b0, 2'b00, {32'h0000FFFF, 32'h12345678});
        send(32'h12345678);
        chk("good_busy_mid", PW'(BUSY), PW'(1'b1));
        send(32'h0000FFFF);
        send(32'h1234A987);
        chk("good_busy_end", PW'(BUSY), '0);
        chk("good_dv", PW'(DATAVALID), PW'(1'b1));

        rearm();
        chk("rearm_data", DATA, '0);
        chk("rearm_dv", PW'(DATAVALID), '0);

        push(1'b0, 1'b1, 2'b01, '0);
        send(32'h12345678);
        send(32'h0000FFFF);
        send(32'h00000000);
        chk("bad_data", DATA, '0);
        chk("bad_dv", PW'(DATAVALID), '0);
        rearm();

        push(1'b0, 1'b1, 2'b10, '0);
        send(32'hA5A5A5A5);
        repeat (7) tick();
        chk("to7_err", PW'(ERR), '0);
        chk("to7_busy", PW'(BUSY), PW'(1'b1));
        tick();
        chk("to8_err", PW'(ERR), PW'(1'b1));
        chk("to8_code", PW'(ERR_CODE), PW'(2'b10));
        chk("to8_busy", PW'(BUSY), '0);
        rearm();

        push(1'b1, 1'b0, 2'b00, {32'h5A5A5A5A, 32'hA5A5A5A5});
        send(32'hA5A5A5A5);
        repeat (7) tick();
        send(32'h5A5A5A5A);
        send(32'hFFFFFFFF);
        chk("idle7_dv", PW'(DATAVALID), PW'(1'b1));

        REARM     = 1'b1;
        CFG_VALID = 1'b1;
        CFG_DATA  = 32'h77777777;
        tick();
        REARM     = 1'b0;
        CFG_VALID = 1'b0;
        CFG_DATA  = '0;
        chk("rearmv_busy", PW'(BUSY), '0);
        chk("rearmv_data", DATA, '0);
        chk("rearmv_dv", PW'(DATAVALID), '0);

        push(1'b1, 1'b0, 2'b00, {32'h22222222, 32'h11111111});
        send(32'h11111111);
        send(32'h22222222);
        send(32'h33333333);
        chk("after_rearm_dv", PW'(DATAVALID), PW'(1'b1));
        rearm();

        send(32'hDEADBEEF);
        send(32'h01020304);
        chk("pre_rst_busy", PW'(BUSY), PW'(1'b1));
        RST = 1'b1;
        #1;
        chk("async_rst_data", DATA, '0);
        chk("async_rst_flags", PW'({DATAVALID, BUSY, ERR, ERR_CODE}), '0);
        tick();
        RST = 1'b0;
        tick();

        push(1'b1, 1'b0, 2'b00, {32'h0BADC0DE, 32'hCAFEF00D});
        send(32'hCAFEF00D);
        send(32'h0BADC0DE);
        send(32'hC15330D3);
        chk("fresh_dv", PW'(DATAVALID), PW'(1'b1));

        for (int i = 0; i < 20 && expq.size() != 0; i++) begin
            tick();
        end
        tick();
        chk("queue_drained", PW'(expq.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
